// File: rtl/accum_cpu_core.sv
// Accumulator CPU core: opcode/address fetch FSM, ALU with Z/C flags, and a
// req/ack memory port that tolerates any number of wait states.
module accum_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              instr_retired
);

  typedef enum logic [2:0] {
    S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_MEM_RD, S_MEM_WR, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0, OP_LDAC = 4'h1, OP_STAC = 4'h2,
                         OP_ADD  = 4'h3, OP_SUB  = 4'h4, OP_AND  = 4'h5,
                         OP_OR   = 4'h6, OP_XOR  = 4'h7, OP_NOT  = 4'h8,
                         OP_INC  = 4'h9, OP_CLR  = 4'hA, OP_JUMP = 4'hB,
                         OP_JMPZ = 4'hC, OP_JMPC = 4'hD, OP_JPNZ = 4'hE,
                         OP_HALT = 4'hF;

  state_t            state;
  logic [ADDR_W-1:0] pc, addr_q, pc_inc, target;
  logic [DATA_W-1:0] ac, lo_q, opnd, alu_res;
  logic [DATA_W:0]   sum, diff;
  logic [3:0]        ir, op_new;
  logic              z, c, done, short_op, is_branch, taken;
  logic              alu_en, alu_wa, alu_wc, alu_c, bus_state;

  always_comb begin
    bus_state = state inside {S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_MEM_RD, S_MEM_WR};
    // Reset gates the request so an open transaction is abandoned at once.
    mem_req   = rst_n & bus_state;
    mem_we    = (state == S_MEM_WR);
    mem_addr  = (state inside {S_MEM_RD, S_MEM_WR}) ? addr_q : pc;
    mem_wdata = ac;
    done      = mem_req & mem_ack;
    op_new    = mem_rdata[DATA_W-1 -: 4];
    short_op  = op_new inside {OP_NOP, OP_NOT, OP_INC, OP_CLR, OP_HALT};
    pc_inc    = pc + ADDR_W'(1);
    target    = ADDR_W'({mem_rdata, lo_q});
    is_branch = ir inside {OP_JUMP, OP_JMPZ, OP_JMPC, OP_JPNZ};
    case (ir)
      OP_JUMP: taken = 1'b1;
      OP_JMPZ: taken = z;
      OP_JMPC: taken = c;
      OP_JPNZ: taken = !z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    opnd    = (ir == OP_INC) ? DATA_W'(1) : mem_rdata;
    sum     = {1'b0, ac} + {1'b0, opnd};
    diff    = {1'b0, ac} - {1'b0, opnd};
    alu_res = ac;
    alu_c   = c;
    alu_wa  = 1'b1;
    alu_wc  = 1'b0;
    case (ir)
      OP_LDAC: alu_res = mem_rdata;
      OP_ADD, OP_INC: begin {alu_c, alu_res} = sum; alu_wc = 1'b1; end
      OP_SUB:  begin {alu_c, alu_res} = diff; alu_wc = 1'b1; end
      OP_AND:  alu_res = ac & mem_rdata;
      OP_OR:   alu_res = ac | mem_rdata;
      OP_XOR:  alu_res = ac ^ mem_rdata;
      OP_NOT:  alu_res = ~ac;
      OP_CLR:  alu_res = '0;
      default: alu_wa = 1'b0;
    endcase
    alu_en        = (state == S_EXEC) | ((state == S_MEM_RD) & done);
    instr_retired = (state == S_EXEC) | ((state inside {S_MEM_RD, S_MEM_WR}) & done)
                  | ((state == S_FETCH_HI) & done & is_branch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH_OP;
      pc     <= RESET_PC;
      ac     <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      ir     <= '0;
      lo_q   <= '0;
      addr_q <= '0;
    end else begin
      if (alu_en) begin
        if (alu_wa) begin
          ac <= alu_res;
          z  <= (alu_res == '0);
        end
        if (alu_wc) c <= alu_c;
      end
      case (state)
        S_FETCH_OP: if (done) begin
          ir    <= op_new;
          pc    <= pc_inc;
          state <= short_op ? S_EXEC : S_FETCH_LO;
        end
        S_FETCH_LO: if (done) begin
          lo_q  <= mem_rdata;
          pc    <= pc_inc;
          state <= S_FETCH_HI;
        end
        S_FETCH_HI: if (done) begin
          addr_q <= target;
          if (is_branch) begin
            pc    <= taken ? target : pc_inc;
            state <= S_FETCH_OP;
          end else begin
            pc    <= pc_inc;
            state <= (ir == OP_STAC) ? S_MEM_WR : S_MEM_RD;
          end
        end
        S_MEM_RD, S_MEM_WR: if (done) state <= S_FETCH_OP;
        S_EXEC:  state <= (ir == OP_HALT) ? S_HALT : S_FETCH_OP;
        default: state <= S_HALT;
      endcase
    end
  end

  assign acc_out = ac;
  assign pc_out  = pc;
  assign flag_z  = z;
  assign flag_c  = c;
  assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed bench for accum_cpu_core: default 8/15 core on a wait-state RAM model
// plus a 4/6 core starting at PC 63 for wrap-around checks.
module tb_accum_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, acc_out;
  logic [14:0] pc_out;
  logic        flag_z, flag_c, halted, instr_retired;

  logic        rst4 = 1'b0;
  logic        req4, we4, ack4, z4, c4, halted4, ret4;
  logic [5:0]  addr4, pc4;
  logic [3:0]  wdata4, rdata4, acc4;

  logic [7:0]  mem [0:1023];
  logic [3:0]  mem4 [0:63];

  int total = 0, bad = 0;
  int retired = 0, wr_count = 0, stab_viol = 0;
  int unsigned wait_max = 0, wait_cnt = 0;
  bit block_we = 0, pend = 0;
  logic [14:0] last_waddr, s_addr;
  logic [7:0]  last_wdata, s_wdata;
  logic        s_we;

  always #5 clk = ~clk;

  accum_cpu_core dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .acc_out(acc_out), .pc_out(pc_out),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .instr_retired(instr_retired)
  );

  accum_cpu_core #(.DATA_W(4), .ADDR_W(6), .RESET_PC(6'd63)) dut4 (
    .clk(clk), .rst_n(rst4), .mem_req(req4), .mem_we(we4),
    .mem_addr(addr4), .mem_wdata(wdata4), .mem_ack(ack4),
    .mem_rdata(rdata4), .acc_out(acc4), .pc_out(pc4),
    .flag_z(z4), .flag_c(c4), .halted(halted4), .instr_retired(ret4)
  );

  assign mem_rdata = mem[mem_addr[9:0]];
  assign rdata4    = mem4[addr4];
  assign ack4      = req4;

  // Ack is decided mid-cycle; wait_cnt holds the remaining wait states.
  always @(negedge clk) begin
    if (mem_req && !(block_we && mem_we) && wait_cnt == 0) mem_ack = 1'b1;
    else begin
      mem_ack = 1'b0;
      if (mem_req && wait_cnt > 0) wait_cnt--;
    end
  end

  always @(posedge clk) begin
    if (pend && mem_req && (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata))
      stab_viol++;
    pend    = mem_req && !mem_ack;
    s_addr  = mem_addr;
    s_we    = mem_we;
    s_wdata = mem_wdata;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr[9:0]] = mem_wdata;
        wr_count++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      wait_cnt = $urandom_range(0, wait_max);
    end
    if (instr_retired) retired++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h00; mem[2]  = 8'h01;
    mem[3] = 8'h30; mem[4] = 8'h01; mem[5]  = 8'h01;
    mem[6] = 8'h20; mem[7] = 8'h02; mem[8]  = 8'h01;
    mem[9] = 8'hF0;
    mem[10'h100] = 8'hF0;
    mem[10'h101] = 8'h20;
  endtask

  // Reset held for two edges, released on a falling edge, sampled 1 ns later.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wait_cnt = 0;
    retired = 0;
    wr_count = 0;
    stab_viol = 0;
    pend = 0;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem4[i] = 4'h0;
    mem4[0] = 4'h8;
    mem4[1] = 4'h9;
    mem4[2] = 4'hF;

    // Program A, zero wait states
    load_prog_a();
    do_reset();
    chk("rst_req", mem_req, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_z", flag_z, 0);
    chk("rst_c", flag_c, 0);
    step(13);
    chk("a_halt13", halted, 0);
    step(1);
    chk("a_halt14", halted, 1);
    chk("a_retired", retired, 4);
    chk("a_wr_count", wr_count, 1);
    chk("a_waddr", last_waddr, 15'h0102);
    chk("a_wdata", last_wdata, 8'h10);
    chk("a_acc", acc_out, 8'h10);
    chk("a_c", flag_c, 1);
    chk("a_z", flag_z, 0);
    chk("a_pc", pc_out, 15'h000A);
    step(1);
    chk("a_halt_req", mem_req, 0);

    // Program B: branches and logic ops
    clear_mem();
    mem[8'h00] = 8'hA0;
    mem[8'h01] = 8'hC0; mem[8'h02] = 8'h40; mem[8'h03] = 8'h00;
    mem[8'h40] = 8'h90;
    mem[8'h41] = 8'hE0; mem[8'h42] = 8'h80; mem[8'h43] = 8'h00;
    mem[8'h80] = 8'h40; mem[8'h81] = 8'h90; mem[8'h82] = 8'h00;
    mem[8'h83] = 8'hD0; mem[8'h84] = 8'hC0; mem[8'h85] = 8'h00;
    mem[8'h86] = 8'h40; mem[8'h87] = 8'h91; mem[8'h88] = 8'h00;
    mem[8'h89] = 8'hD0; mem[8'h8A] = 8'hC0; mem[8'h8B] = 8'h00;
    mem[8'h90] = 8'h01; mem[8'h91] = 8'h05;
    mem[8'h92] = 8'h04; mem[8'h93] = 8'hFF; mem[8'h94] = 8'h0F;
    mem[8'hC0] = 8'h60; mem[8'hC1] = 8'h92; mem[8'hC2] = 8'h00;
    mem[8'hC3] = 8'h70; mem[8'hC4] = 8'h93; mem[8'hC5] = 8'h00;
    mem[8'hC6] = 8'h80;
    mem[8'hC7] = 8'h50; mem[8'hC8] = 8'h94; mem[8'hC9] = 8'h00;
    mem[8'hCA] = 8'hF0;
    do_reset();
    step(5);
    chk("b_jmpz_pc", pc_out, 15'h0040);
    chk("b_clr_z", flag_z, 1);
    step(5);
    chk("b_jpnz_pc", pc_out, 15'h0080);
    chk("b_inc_acc", acc_out, 8'h01);
    chk("b_inc_z", flag_z, 0);
    step(4);
    chk("b_sub_acc", acc_out, 8'h00);
    chk("b_sub_z", flag_z, 1);
    chk("b_sub_c", flag_c, 0);
    step(3);
    chk("b_jmpc_nt_pc", pc_out, 15'h0086);
    step(4);
    chk("b_borrow_acc", acc_out, 8'hFB);
    chk("b_borrow_c", flag_c, 1);
    step(3);
    chk("b_jmpc_t_pc", pc_out, 15'h00C0);
    step(4);
    chk("b_or_acc", acc_out, 8'hFF);
    step(4);
    chk("b_xor_acc", acc_out, 8'h00);
    chk("b_xor_z", flag_z, 1);
    chk("b_xor_c", flag_c, 1);
    step(2);
    chk("b_not_acc", acc_out, 8'hFF);
    chk("b_not_z", flag_z, 0);
    step(4);
    chk("b_and_acc", acc_out, 8'h0F);
    step(2);
    chk("b_halt", halted, 1);

    // Program A with random 0-3 wait states
    load_prog_a();
    wait_max = 3;
    do_reset();
    for (int i = 0; i < 300 && !halted; i++) step(1);
    chk("d_halt", halted, 1);
    chk("d_acc", acc_out, 8'h10);
    chk("d_c", flag_c, 1);
    chk("d_z", flag_z, 0);
    chk("d_mem", mem[10'h102], 8'h10);
    chk("d_retired", retired, 4);
    chk("d_stable", stab_viol, 0);
    wait_max = 0;

    // Reset while a write is stalled
    load_prog_a();
    do_reset();
    block_we = 1;
    step(13);
    chk("e_req", mem_req, 1);
    chk("e_we", mem_we, 1);
    chk("e_addr", mem_addr, 15'h0102);
    rst_n = 1'b0;
    #1;
    chk("e_req_drop", mem_req, 0);
    step(2);
    chk("e_no_write", wr_count, 0);
    chk("e_mem", mem[10'h102], 8'h00);
    @(negedge clk);
    block_we = 0;
    rst_n = 1'b1;
    #1;
    chk("e_restart_addr", mem_addr, 15'h0000);
    chk("e_restart_req", mem_req, 1);
    chk("e_restart_we", mem_we, 0);

    // Narrow core: PC wrap from 63 and 4-bit carry
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    chk("f_first_addr", addr4, 6'd63);
    step(2);
    chk("f_wrap_addr", addr4, 6'd0);
    chk("f_wrap_pc", pc4, 6'd0);
    step(2);
    chk("f_not_acc", acc4, 4'hF);
    step(2);
    chk("f_inc_acc", acc4, 4'h0);
    chk("f_inc_c", c4, 1);
    chk("f_inc_z", z4, 1);
    step(2);
    chk("f_halt", halted4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
